// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: player-input front end for snake_core.
// Synchronises and (optionally) debounces four raw buttons, turns debounced rising edges
// into press events, rejects repeat/reversal turns, buffers accepted turns in a 2-deep
// FIFO and commits one turn to dir on each game_en step pulse.
//
// Optional feature macro: SNAKE_DIR_DEBOUNCE_EN
//   defined   - per-button 16-bit debouncer, level flips after DEB_CYCLES stable samples
//   undefined - debounced level is the synchroniser output; DEB_CYCLES is ignored
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   btn_up     raw button inputs, asynchronous, active-high
//   btn_down
//   btn_left
//   btn_right
//   game_en    one-cycle step pulse (commit opportunity each high cycle)
//   dir        committed direction: 00=UP, 01=LEFT, 10=RIGHT, 11=DOWN
//   q_count    turn-queue occupancy, 0..2
//   turn_drop  one-cycle pulse the cycle after a press is rejected
module snake_dir_ctrl #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter logic [1:0]  INIT_DIR   = 2'b10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       game_en,
    output logic [1:0] dir,
    output logic [1:0] q_count,
    output logic       turn_drop
);

    localparam logic [1:0] DirUp    = 2'b00;
    localparam logic [1:0] DirLeft  = 2'b01;
    localparam logic [1:0] DirRight = 2'b10;
    localparam logic [1:0] DirDown  = 2'b11;

    // Bit order: 0=up, 1=down, 2=left, 3=right (matches press priority).
    logic [3:0] raw;
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] level;
    logic [3:0] level_prev_q;

    assign raw = {btn_right, btn_left, btn_down, btn_up};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 4'b0;
            sync2_q <= 4'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef SNAKE_DIR_DEBOUNCE_EN
    localparam logic [15:0] DebLast = 16'(DEB_CYCLES - 1);

    logic [3:0]  deb_q, deb_d;
    logic [15:0] cnt_q [4];
    logic [15:0] cnt_d [4];

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = 16'd0;
            end else if (cnt_q[i] == DebLast) begin
                deb_d[i] = ~deb_q[i];
                cnt_d[i] = 16'd0;
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_q <= 4'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 16'd0;
            end
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level = deb_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            level_prev_q <= 4'b0;
        end else begin
            level_prev_q <= level;
        end
    end

    // Turn queue: entry0 is the head, entry1 only valid when count is 2.
    logic [1:0] dir_q, dir_d;
    logic [1:0] entry0_q, entry0_d;
    logic [1:0] entry1_q, entry1_d;
    logic [1:0] count_q, count_d;
    logic       drop_q, drop_d;

    logic [3:0] press;
    logic       press_valid;
    logic [1:0] press_dir;
    logic [1:0] ref_dir;
    logic       accept;
    logic       pop;
    logic [1:0] count_after_pop;

    assign press = level & ~level_prev_q;

    always_comb begin
        press_valid = 1'b1;
        press_dir   = DirUp;
        if (press[0]) begin
            press_dir = DirUp;
        end else if (press[1]) begin
            press_dir = DirDown;
        end else if (press[2]) begin
            press_dir = DirLeft;
        end else if (press[3]) begin
            press_dir = DirRight;
        end else begin
            press_valid = 1'b0;
        end
    end

    always_comb begin
        dir_d    = dir_q;
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        drop_d   = 1'b0;

        // Reference uses the pre-pop tail so a same-cycle commit cannot mask a reversal.
        if (count_q == 2'd2) begin
            ref_dir = entry1_q;
        end else if (count_q == 2'd1) begin
            ref_dir = entry0_q;
        end else begin
            ref_dir = dir_q;
        end

        accept = press_valid && (count_q < 2'd2) && (press_dir != ref_dir) &&
                 (press_dir != ~ref_dir);
        drop_d = press_valid && !accept;
        pop    = game_en && (count_q != 2'd0);

        count_after_pop = count_q;
        if (pop) begin
            dir_d           = entry0_q;
            entry0_d        = entry1_q;
            count_after_pop = count_q - 2'd1;
        end

        if (accept) begin
            if (count_after_pop == 2'd0) begin
                entry0_d = press_dir;
            end else begin
                entry1_d = press_dir;
            end
            count_d = count_after_pop + 2'd1;
        end else begin
            count_d = count_after_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q    <= INIT_DIR;
            entry0_q <= 2'b00;
            entry1_q <= 2'b00;
            count_q  <= 2'd0;
            drop_q   <= 1'b0;
        end else begin
            dir_q    <= dir_d;
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    assign dir       = dir_q;
    assign q_count   = count_q;
    assign turn_drop = drop_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Testbench for snake_dir_ctrl: directed scenarios plus randomized button/step traffic.
// A reference model predicts dir/q_count/turn_drop after every clock edge and pushes the
// prediction into a scoreboard queue; a monitor pops and compares on each falling edge.
module tb_snake_dir_ctrl;

    localparam int unsigned DEB  = 4;
    localparam logic [1:0]  INIT = 2'b10;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;   // 0=up, 1=down, 2=left, 3=right
    logic       game_en;
    logic [1:0] dir;
    logic [1:0] q_count;
    logic       turn_drop;

    always #5 clk = ~clk;

    snake_dir_ctrl #(
        .DEB_CYCLES(DEB),
        .INIT_DIR  (INIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn[0]),
        .btn_down (btn[1]),
        .btn_left (btn[2]),
        .btn_right(btn[3]),
        .game_en  (game_en),
        .dir      (dir),
        .q_count  (q_count),
        .turn_drop(turn_drop)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] dir;
        logic [1:0] cnt;
        logic       drop;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state.
    logic [1:0] m_dir;
    logic [1:0] m_turns[$];
    logic       m_drop;
    logic [3:0] m_s1, m_s2, m_lvl, m_prev;
    int         m_run[4];

    function automatic logic [1:0] btn_code(int idx);
        case (idx)
            0:       return 2'b00;
            1:       return 2'b11;
            2:       return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    task automatic model_step();
        logic [3:0] press;
        int         win;
        logic [1:0] d, rdir;
        bit         ok;
        exp_t       e;
        if (rst) begin
            m_dir = INIT;
            m_turns.delete();
            m_drop = 1'b0;
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prev = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            press  = m_lvl & ~m_prev;
            m_drop = 1'b0;
            win    = -1;
            ok     = 1'b0;
            d      = 2'b00;
            for (int i = 3; i >= 0; i--) if (press[i]) win = i;
            if (win >= 0) begin
                d    = btn_code(win);
                rdir = (m_turns.size() > 0) ? m_turns[$] : m_dir;
                ok   = (m_turns.size() < 2) && (d != rdir) && (d != ~rdir);
            end
            if (game_en && m_turns.size() > 0) m_dir = m_turns.pop_front();
            if (win >= 0) begin
                if (ok) m_turns.push_back(d);
                else m_drop = 1'b1;
            end
            m_prev = m_lvl;
`ifdef SNAKE_DIR_DEBOUNCE_EN
            // Level follows the sample once it has disagreed for DEB consecutive cycles.
            for (int i = 0; i < 4; i++) begin
                m_run[i] = (m_s2[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
                if (m_run[i] == DEB) begin
                    m_lvl[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end
`endif
            m_s2 = m_s1;
            m_s1 = btn;
`ifndef SNAKE_DIR_DEBOUNCE_EN
            m_lvl = m_s2;
`endif
        end
        e.dir  = m_dir;
        e.cnt  = 2'(m_turns.size());
        e.drop = m_drop;
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: the DUT presents a fresh output set after every edge.
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t: no expected entry available", $time);
            end else begin
                e = exp_q.pop_front();
                if (dir !== e.dir || q_count !== e.cnt || turn_drop !== e.drop) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got dir=%b q_count=%0d turn_drop=%b, want dir=%b q_count=%0d turn_drop=%b",
                             $time, dir, q_count, turn_drop, e.dir, e.cnt, e.drop);
                end
            end
        end
    end

    task automatic cycles(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(logic [3:0] m, int hold);
        btn = m;
        cycles(hold);
        btn = 4'b0;
        cycles(hold);
    endtask

    task automatic step_pulse();
        game_en = 1'b1;
        cycles(1);
        game_en = 1'b0;
        cycles(2);
    endtask

    initial begin
        rst     = 1'b1;
        btn     = 4'b0;
        game_en = 1'b0;
        cycles(3);
        rst = 1'b0;

        cycles(50);                     // idle after reset

        press(4'b0001, 10);             // legal UP turn
        step_pulse();
        press(4'b1000, 10);             // back to RIGHT
        step_pulse();
        press(4'b0100, 10);             // LEFT while RIGHT: reversal
        press(4'b1000, 10);             // RIGHT while RIGHT: repeat

        press(4'b0001, 10);             // double tap UP, LEFT
        press(4'b0100, 10);
        press(4'b0010, 10);             // DOWN with full queue
        step_pulse();
        step_pulse();

        for (int i = 0; i < 10; i++) begin   // bouncing DOWN
            btn = 4'b0010; cycles(2);
            btn = 4'b0000; cycles(2);
        end
        press(4'b0010, 8);

        press(4'b0101, 10);             // UP and LEFT together
        step_pulse();

        press(4'b1000, 10);             // fill queue then reset
        press(4'b0001, 10);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(5);

        for (int k = 0; k < 400; k++) begin
            int hold;
            hold = $urandom_range(1, 12);
            btn  = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
            for (int c = 0; c < hold; c++) begin
                game_en = ($urandom_range(0, 5) == 0);
                rst     = ($urandom_range(0, 299) == 0);
                cycles(1);
            end
            rst     = 1'b0;
            game_en = 1'b0;
        end

        btn = 4'b0;
        cycles(3);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
Player-input front end that sits directly upstream of snake_core and drives its dir input. It synchronises and debounces four raw push-buttons, detects presses, and rejects illegal turns (repeat or 180° reversal). Accepted turns go into a 2-deep turn queue, and one turn is committed to dir on each game_en step pulse. Two quick presses within one step therefore both take effect, on consecutive steps.

Parameters:
DEB_CYCLES, 16, consecutive stable synchronised samples required before a debounced button level changes (range 1..65535)
INIT_DIR, 2'b10, dir value after reset (RIGHT)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
btn_up  input  1  raw button, asynchronous, active-high
btn_down  input  1  raw button, asynchronous, active-high
btn_left  input  1  raw button, asynchronous, active-high
btn_right  input  1  raw button, asynchronous, active-high
game_en  input  1  one-cycle step pulse, the same signal that feeds snake_core
dir  output  2  committed direction to snake_core; 00=UP, 01=LEFT, 10=RIGHT, 11=DOWN
q_count  output  2  turn-queue occupancy, 0..2
turn_drop  output  1  one-cycle pulse when a press is rejected

Behaviour:
- Clocking and reset: single clock domain; all state updates on posedge clk; rst is synchronous and active-high.
- Reset values: dir=INIT_DIR, q_count=0, turn_drop=0. Synchroniser flops, debounced levels and debounce counters are all cleared (buttons read as released).
- Reset mid-operation: the queue is flushed and no pending turn survives reset.
- Synchroniser: each button passes through a 2-flop synchroniser.
- Debouncer, per button: a 16-bit counter.
  - Counter clears whenever the synchronised sample equals the debounced level.
  - Otherwise it increments.
  - When it reaches DEB_CYCLES-1 with the sample still different, the debounced level flips and the counter clears.
  - Any glitch shorter than DEB_CYCLES cycles produces no level change.
- Press event: rising edge of the debounced level, lasting one cycle.
  - Multiple press events in the same cycle are resolved by priority UP > DOWN > LEFT > RIGHT.
  - Only the winning press is evaluated; the losers are discarded silently, with no turn_drop.
- Reference direction: the tail of the queue if q_count>0, otherwise dir.
- Acceptance rule: a press for direction d is accepted only if all of the following hold:
  - q_count (value before any same-cycle pop) < 2;
  - d != reference direction;
  - d != ~reference direction (bitwise inverse = reversal).
  - On rejection, turn_drop=1 on the next cycle.
- Queue: 2-entry FIFO with push at the tail and pop at the head.
- Commit: on a cycle with game_en=1 and q_count>0, dir <= head and the head is popped. dir is visible from the next cycle, so snake_core applies it on its following step.
- Simultaneous push and pop: both occur and q_count is unchanged. The reference direction uses the pre-pop tail.
- Full queue with a same-cycle pop: the press is dropped (turn_drop=1) and the pop proceeds.
- game_en with an empty queue: dir holds.
- game_en held high for several cycles: each high cycle is a separate commit opportunity; no edge detection is applied.
- Latency: raw press to queue entry = 2 (sync) + DEB_CYCLES + 1 cycles; queue entry to dir = the next game_en + 1 cycle.

Optional Feature:
SNAKE_DIR_DEBOUNCE_EN
- Defined: the debouncer operates as described above.
- Undefined: debouncers and their counters are not instantiated. The debounced level equals the synchroniser output directly (press latency = 2 cycles + 1). DEB_CYCLES is ignored.
- Acceptance, queue and commit logic are identical in both builds.

Test Plan:
- Reset then idle: after rst deasserts, dir=2'b10, q_count=0, turn_drop=0 held for 50 cycles with no buttons pressed.
- Legal turn (DEB_CYCLES=4): hold btn_up 10 cycles → q_count=1 at cycle 7 after press; next game_en → dir=2'b00 the following cycle, q_count=0.
- Reversal and repeat rejection, with dir=RIGHT:
  - btn_left press → turn_drop pulses once, q_count stays 0;
  - btn_right press → turn_drop pulses once, dir unchanged.
- Double-tap buffering, with dir=RIGHT and no game_en:
  - press UP then LEFT → q_count=2;
  - press DOWN → turn_drop (queue full);
  - two game_en pulses → dir becomes 00, then 01.
- Bounce filter (debounce build, DEB_CYCLES=4): btn_down toggles every 2 cycles for 20 cycles → no press event, q_count=0, no turn_drop. Then hold 8 cycles → q_count=1.
- Simultaneous events:
  - btn_up and btn_left press in the same cycle with dir=RIGHT → only UP queued.
  - A press coinciding with game_en while q_count=1 → pop and push both occur, q_count stays 1.
  - rst asserted with q_count=2 → q_count=0 and dir=INIT_DIR next cycle.
